serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial ripple adder. Registers two WIDTH-bit operands, then adds them one
//  bit per clock, LSB first, through a single full-adder cell (two half-adders
//  plus an OR) and a carry flip-flop.
//  Sits upstream of result consumers that tolerate a WIDTH+1 cycle latency, and
//  replaces a WIDTH-wide parallel full-adder chain where area matters more than speed.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range >= 1
// PORTS
//  clk     input   1      rising-edge clock, single clock domain
//  rst     input   1      synchronous, active-high reset
//  start   input   1      request; sampled only in IDLE
//  a       input   WIDTH  operand A; sampled with start
//  b       input   WIDTH  operand B; sampled with start
//  cin     input   1      carry-in; sampled with start
//  busy    output  1      high in ADD and DONE states
//  done    output  1      one-cycle pulse: sum/cout just updated
//  sum     output  WIDTH  result of last completed add; held until next completion
//  cout    output  1      carry-out of last completed add; held likewise
// BEHAVIOUR
//  Reset: rst high at a rising edge -> state=IDLE.
//   Also clears busy, done, sum, cout, the carry FF, the bit counter and the shift regs.
//   Reset aborts any add in progress; the partial result is discarded.
//  FSM states: IDLE, ADD, DONE.
//   IDLE: start=1 -> load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0; go to ADD.
//     start=0 -> stay in IDLE.
//   ADD: each cycle, full-add fa_s/fa_c = FA(a_sr[0], b_sr[0], carry).
//     a_sr, b_sr shift right 1; fa_s is shifted into res_sr at the MSB; carry<=fa_c.
//     cnt<=cnt+1. On the cycle where cnt==WIDTH-1, go to DONE.
//     On that same edge: sum<={fa_s,res_sr[WIDTH-1:1]} and cout<=fa_c.
//   DONE: done=1 for exactly this one cycle; go to IDLE unconditionally.
//  Latency: start sampled at edge k -> ADD on edges k+1..k+WIDTH.
//   sum/cout update and done rises at edge k+WIDTH; done falls at edge k+WIDTH+1.
//   Next start is accepted at edge k+WIDTH+1 at the earliest (throughput 1 per WIDTH+1 cycles).
//  Handshake: start while busy=1 (ADD or DONE) is ignored and not queued.
//   Changes on a, b or cin are ignored while busy=1.
//  Outputs: sum/cout change only at the completion edge.
//   They are not cleared by start, so they stay stable through the next add.
//  Arithmetic: {cout,sum} == a + b + cin, taken modulo 2^(WIDTH+1) with no overflow flag.
//  Widths: cnt is $clog2(WIDTH+1) bits. WIDTH=1 gives one ADD cycle.
//  Simultaneous rst and start: rst wins, start is dropped.
//  X safety: no output may go X after reset, whatever the inputs are.
// TESTING
//  1 WIDTH=8: a=00, b=00, cin=0 -> done at +8; sum=00, cout=0; busy high 9 cycles.
//  2 WIDTH=8: a=FF, b=01, cin=0 -> sum=00, cout=1.
//    a=A5, b=5A, cin=1 -> sum=00, cout=1.
//  3 start pulsed again at +3 with a=11, b=22 -> ignored; result is still first add.
//    start at +9 -> accepted; sum=33, cout=0 at +17.
//  4 rst at +4 mid-add (previous sum=7F) -> sum=00, cout=0, busy=0 next cycle.
//    done never pulses for the aborted add.
//  5 WIDTH=1: all 8 {a,b,cin} combos -> {cout,sum} == a+b+cin; done 1 cycle after start.
//  6 Random: 1000 WIDTH=8 operand sets, back-to-back starts.
//    {cout,sum} matches the reference a+b+cin every time.
//    sum stays unchanged between completions.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are latched on start, then summed LSB first through one
// full-adder cell and a carry flip-flop, finishing WIDTH cycles later with a done pulse.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
   logic [WIDTH:0]   res_ext;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             fa_s, fa_c;
   logic             last;

   // Two half-adders plus an OR; returns {carry, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      logic s1, c1, c2;
      s1 = x ^ y;
      c1 = x & y;
      c2 = s1 & ci;
      return {c1 | c2, s1 ^ ci};
   endfunction

   assign {fa_c, fa_s} = full_add(a_sr[0], b_sr[0], carry);
   // Concatenate-then-slice keeps the MSB insertion legal for WIDTH=1.
   assign res_ext      = {fa_s, res_sr};
   assign res_nxt      = res_ext[WIDTH:1];
   assign last         = (cnt == CNT_W'(WIDTH - 1));

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ADD;
         ADD:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            ADD: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_nxt;
               carry  <= fa_c;
               cnt    <= cnt + CNT_W'(1);
               // Outputs move only on the completion edge so they hold through the next add.
               if (last) begin
                  sum  <= res_nxt;
                  cout <= fa_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
